// File: rtl/seg7_scan.sv
// seg7_scan -- time-multiplexed driver for an eight-digit, common-anode,
// seven-segment display. Shows a 32-bit word as eight hex digits with
// per-digit decimal points. Data is captured once per scan frame so a digit
// never changes partway through a frame. Each digit slot starts with a
// programmable blanking interval to suppress ghosting.
//
// Parameters:
//   DIGIT_CYCLES  clock cycles per digit slot (>= 2)
//   BLANK_CYCLES  blank cycles at the start of each slot (0 .. DIGIT_CYCLES-1)
//
// Ports:
//   CLK     in   1   system clock
//   Reset   in   1   synchronous, active-high reset
//   Data    in  32   word to display; nibble k drives digit k (digit 0 rightmost)
//   DPMask  in   8   bit k lights the decimal point of digit k
//   A2G     out  7   segment cathodes {a,b,c,d,e,f,g}, active-low, registered
//   AN      out  8   digit anodes, AN[k] drives digit k, active-low, registered
//   DP      out  1   decimal-point cathode, active-low, registered
module seg7_scan #(
   parameter int DIGIT_CYCLES = 100000,
   parameter int BLANK_CYCLES = 1000
) (
   input  logic        CLK,
   input  logic        Reset,
   input  logic [31:0] Data,
   input  logic [7:0]  DPMask,
   output logic [6:0]  A2G,
   output logic [7:0]  AN,
   output logic        DP
);

   localparam int CW = (DIGIT_CYCLES > 2) ? $clog2(DIGIT_CYCLES) : 1;

   logic [CW-1:0] cnt;
   logic [2:0]    idx;
   logic [31:0]   shadow_data;
   logic [7:0]    shadow_dp;

   logic          slot_end;
   logic          blank;
   logic [3:0]    nibble;

   assign slot_end = (cnt == CW'(DIGIT_CYCLES - 1));
   assign nibble   = shadow_data[{idx, 2'b00} +: 4];

   // Split out the zero case so the comparison never degenerates into a
   // constant-false unsigned compare.
   generate
      if (BLANK_CYCLES == 0) begin : g_noblank
         assign blank = 1'b0;
      end else begin : g_blank
         assign blank = (cnt < CW'(BLANK_CYCLES));
      end
   endgenerate

   // Active-low hex decode, segment order {a,b,c,d,e,f,g}.
   function automatic logic [6:0] hex7(input logic [3:0] n);
      case (n)
         4'h0: hex7 = 7'h01;
         4'h1: hex7 = 7'h4F;
         4'h2: hex7 = 7'h12;
         4'h3: hex7 = 7'h06;
         4'h4: hex7 = 7'h4C;
         4'h5: hex7 = 7'h24;
         4'h6: hex7 = 7'h20;
         4'h7: hex7 = 7'h0F;
         4'h8: hex7 = 7'h00;
         4'h9: hex7 = 7'h04;
         4'hA: hex7 = 7'h08;
         4'hB: hex7 = 7'h60;
         4'hC: hex7 = 7'h31;
         4'hD: hex7 = 7'h42;
         4'hE: hex7 = 7'h30;
         default: hex7 = 7'h38;
      endcase
   endfunction

   always_ff @(posedge CLK) begin
      if (Reset) begin
         cnt         <= '0;
         idx         <= '0;
         shadow_data <= '0;
         shadow_dp   <= '0;
         AN          <= 8'hFF;
         A2G         <= 7'h7F;
         DP          <= 1'b1;
      end else begin
         if (slot_end) begin
            cnt <= '0;
            idx <= idx + 3'd1;
            // Last cycle of digit 7: capture the next frame's content.
            if (idx == 3'd7) begin
               shadow_data <= Data;
               shadow_dp   <= DPMask;
            end
         end else begin
            cnt <= cnt + CW'(1);
         end

         // Outputs reflect this cycle's cnt/idx/shadow, visible next cycle.
         if (blank) begin
            AN  <= 8'hFF;
            A2G <= 7'h7F;
            DP  <= 1'b1;
         end else begin
            AN  <= ~(8'b1 << idx);
            A2G <= hex7(nibble);
            DP  <= ~shadow_dp[idx];
         end
      end
   end

endmodule

// File: tb/tb_seg7_scan.sv
// Directed, table-driven bench for seg7_scan with DIGIT_CYCLES=8,
// BLANK_CYCLES=2 (64-cycle frames). Each table record holds a word to show,
// its decimal-point mask, the step within the preceding frame at which it is
// driven, and the hand-decoded segment/DP values expected for each digit.
module tb_seg7_scan;
   localparam int DC = 8;
   localparam int BC = 2;
   localparam int FRAME = 8 * DC;

   logic        CLK = 1'b0;
   logic        Reset = 1'b1;
   logic [31:0] Data = '0;
   logic [7:0]  DPMask = '0;
   logic [6:0]  A2G;
   logic [7:0]  AN;
   logic        DP;

   int applied = 0;
   int errs = 0;

   seg7_scan #(.DIGIT_CYCLES(DC), .BLANK_CYCLES(BC)) dut (
      .CLK(CLK), .Reset(Reset), .Data(Data), .DPMask(DPMask),
      .A2G(A2G), .AN(AN), .DP(DP)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      string       name;
      logic [31:0] data;
      logic [7:0]  dpm;
      int          apply_at;   // step within previous frame where it is driven
      logic [55:0] segs;       // digit k expected A2G at [7k+6:7k]
      logic [7:0]  dpn;        // expected DP per digit (active-low)
   } vec_t;

   vec_t       vecs[4];
   logic [7:0] an_tab[8];

   task automatic check(input string nm, input logic [7:0] an_e,
                        input logic [6:0] seg_e, input logic dp_e);
      applied++;
      if (AN !== an_e || A2G !== seg_e || DP !== dp_e) begin
         errs++;
         $display("FAIL %s: got AN=%h A2G=%h DP=%b, want AN=%h A2G=%h DP=%b",
                  nm, AN, A2G, DP, an_e, seg_e, dp_e);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // Walks nsteps output cycles from the start of a frame, checking each.
   // Optionally drives new Data/DPMask before the edge of step 'at'.
   task automatic run_frame(input string nm, input logic [55:0] segs,
                            input logic [7:0] dpn, input int nsteps,
                            input logic drive, input logic [31:0] nd,
                            input logic [7:0] ndp, input int at);
      for (int s = 0; s < nsteps; s++) begin
         if (drive && s == at) begin
            Data   = nd;
            DPMask = ndp;
         end
         step();
         if (s % DC < BC)
            check(nm, 8'hFF, 7'h7F, 1'b1);
         else
            check(nm, an_tab[s / DC], segs[(s / DC) * 7 +: 7], dpn[s / DC]);
      end
   endtask

   initial begin
      an_tab = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
      vecs[0] = '{"hex_decode", 32'hFEDCBA98, 8'h00, 0,
                  {7'h38, 7'h30, 7'h42, 7'h31, 7'h60, 7'h08, 7'h04, 7'h00}, 8'hFF};
      vecs[1] = '{"digits_dp81", 32'h76543210, 8'h81, 10,
                  {7'h0F, 7'h20, 7'h24, 7'h4C, 7'h06, 7'h12, 7'h4F, 7'h01}, 8'h7E};
      // Driven mid-frame (digit 3, cnt 3) while 76543210 is on display.
      vecs[2] = '{"frame_capture", 32'hFFFFFFFF, 8'h00, 27,
                  {8{7'h38}}, 8'hFF};
      // Driven exactly on the latch cycle of the previous frame.
      vecs[3] = '{"latch_edge_dpall", 32'h13579BDF, 8'hFF, 63,
                  {7'h4F, 7'h06, 7'h24, 7'h0F, 7'h04, 7'h60, 7'h42, 7'h38}, 8'h00};

      // Reset held for 3 cycles
      for (int i = 0; i < 3; i++) begin
         step();
         check("reset_hold", 8'hFF, 7'h7F, 1'b1);
      end
      Reset = 1'b0;

      // First frame shows the cleared shadow
      run_frame("frame0_zero", {8{7'h01}}, 8'hFF, FRAME,
                1'b1, vecs[0].data, vecs[0].dpm, vecs[0].apply_at);

      for (int i = 0; i < 4; i++) begin
         int j;
         j = (i < 3) ? i + 1 : i;
         run_frame(vecs[i].name, vecs[i].segs, vecs[i].dpn, FRAME,
                   i < 3, vecs[j].data, vecs[j].dpm, vecs[j].apply_at);
      end

      // Reset mid-frame at idx=4, cnt=5 (frame step 37)
      run_frame("pre_reset", vecs[3].segs, vecs[3].dpn, 4 * DC + 5,
                1'b0, 32'h0, 8'h0, 0);
      Reset = 1'b1;
      step();
      check("reset_mid", 8'hFF, 7'h7F, 1'b1);
      Reset = 1'b0;
      run_frame("post_reset", {8{7'h01}}, 8'hFF, FRAME,
                1'b0, 32'h0, 8'h0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", applied, errs);
      $finish;
   end
endmodule
